proc_scycle: RTL and testbench
==============================

// Module: proc_scycle
// PURPOSE
//   Single-cycle TinyRV1 processor core: fetches, decodes, executes and
//   commits one instruction per clock. Connects to a combinational
//   instruction/data test memory, exposes three input and three output
//   CSR ports, and emits a per-instruction commit trace for checking.
// PARAMETERS
//   RESET_PC  32'h0000_0200  address of the first instruction fetched after reset
// PORTS
//   clk             in   1   single clock, rising edge
//   rst             in   1   asynchronous, active-high reset
//   imemreq_val     out  1   instruction fetch valid
//   imemreq_addr    out  32  fetch address (= PC)
//   imemresp_data   in   32  instruction word, combinational, same cycle
//   dmemreq_val     out  1   data request valid (lw/sw only)
//   dmemreq_type    out  1   0 = read (lw), 1 = write (sw)
//   dmemreq_addr    out  32  data address (rs1 + imm)
//   dmemreq_wdata   out  32  store data (rs2)
//   dmemresp_rdata  in   32  load data, combinational, same cycle
//   in0/in1/in2     in   32  CSR inputs, read by csrr
//   out0/out1/out2  out  32  CSR output registers, written by csrw
//   trace_val       out  1   an instruction commits this cycle
//   trace_addr      out  32  PC of the committing instruction
//   trace_data      out  32  value written to rd; all-X if no rd write
// BEHAVIOUR
// - Reset (async): PC <= RESET_PC; out0..2 <= 0. While rst is high, imemreq_val,
//   dmemreq_val and trace_val are 0. Register file is not reset.
// - Out of reset, every cycle: imemreq_val=1, trace_val=1, one instruction
//   commits at the rising edge. CPI = 1, no stalls, no pipeline.
// - x0 reads 0; writes to x0 are discarded, but trace_data still shows the computed value.
// - Register file: 2 combinational reads, 1 synchronous write.
// - Instructions (RV32 encodings; immediates sign-extended to 32 bits):
//     add   rd = rs1 + rs2                       PC+4
//     addi  rd = rs1 + immI (-2048..2047)        PC+4
//     mul   rd = low 32 bits of rs1*rs2          PC+4
//     lw    rd = mem[rs1+immI]                   PC+4
//     sw    mem[rs1+immS] = rs2; no rd write     PC+4
//     jal   rd = PC+4;                           PC = PC+immJ
//     jr    no rd write;                         PC = rs1
//     bne   no rd write;                         PC = (rs1!=rs2) ? PC+immB : PC+4
//     csrr  rd = in0/in1/in2 for CSR 0xFC2/0xFC3/0xFC4      PC+4
//     csrw  out0/out1/out2 = rs1 for CSR 0x7C2/0x7C3/0x7C4; no rd write   PC+4
// - Arithmetic wraps modulo 2^32 and carries are dropped.
//   Example: addi 0x7FFFFFFF + 1 gives 0x80000000.
// - dmemreq_* are driven only for lw/sw; at all other times dmemreq_val=0.
//   The write occurs at the clock edge.
// - Undecoded/illegal instruction: acts as a nop (no state change, PC+4).
//   It still commits with trace_val=1 and trace_data all-X.
// - Trace outputs are combinational from the current PC/instruction and are
//   valid before the committing edge.
// TESTING
// - Reset, then addi x1,x0,2 at 0x200 -> trace (0x200, 0x00000002); next trace addr 0x204.
// - Chain: addi x1,x0,2; addi x2,x1,3; addi x3,x2,-7 -> data 2, 5, 0xFFFFFFFE.
// - Immediate limits: addi x1,x0,2047 -> 0x7FF; addi x2,x0,-2048 -> 0xFFFFF800.
// - Wrap: x1=0x7FFFFFFF; addi x1,x1,1 -> 0x80000000.
//   addi x0,x0,5 -> trace 5, but a later addi x1,x0,0 -> 0.
// - Control/memory: bne taken to 0x210 -> next trace_addr 0x210 with data X.
//   sw then lw at the same address -> lw trace_data equals the stored value.
// - CSR: in0=0x1234; csrr x1,in0 -> 0x1234; csrw out0,x1 -> out0=0x1234 the next cycle.
//   Async reset mid-run -> trace_val=0 immediately, then a restart at 0x200.

Source files
------------

// File: rtl/proc_scycle.sv
// ---------------------------------------------------------------------------
// proc_scycle -- single-cycle TinyRV1 processor core.
//
// One instruction is fetched, decoded, executed and committed every clock.
// Instruction and data memories answer combinationally in the same cycle, so
// the whole datapath from PC to the next PC and the register write is a single
// combinational path.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   imemreq_val      fetch valid (high whenever out of reset)
//   imemreq_addr     fetch address, equal to the PC
//   imemresp_data    instruction word for imemreq_addr
//   dmemreq_val      data request valid, lw/sw only
//   dmemreq_type     0 = read (lw), 1 = write (sw)
//   dmemreq_addr     rs1 + sign-extended offset
//   dmemreq_wdata    store data (rs2)
//   dmemresp_rdata   load data for dmemreq_addr
//   in0..in2         CSR inputs read by csrr (0xFC2..0xFC4)
//   out0..out2       CSR output registers written by csrw (0x7C2..0x7C4)
//   trace_val        an instruction commits this cycle
//   trace_addr       PC of the committing instruction
//   trace_data       value written to rd, all-X when there is no rd write
// ---------------------------------------------------------------------------
module proc_scycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemreq_val,
  output logic [31:0] imemreq_addr,
  input  logic [31:0] imemresp_data,
  output logic        dmemreq_val,
  output logic        dmemreq_type,
  output logic [31:0] dmemreq_addr,
  output logic [31:0] dmemreq_wdata,
  input  logic [31:0] dmemresp_rdata,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2,
  output logic        trace_val,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  typedef enum logic [3:0] {
    OP_ILL, OP_ADD, OP_ADDI, OP_MUL, OP_LW, OP_SW,
    OP_JAL, OP_JR, OP_BNE, OP_CSRR, OP_CSRW
  } op_e;

  logic [31:0] pc;
  logic [31:0] ir;
  op_e         op;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] csr;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;

  logic [31:0] rf [1:31];
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  logic        wb_en;
  logic [31:0] wb_data;
  logic [31:0] next_pc;
  logic        dmem_en;

  assign ir     = imemresp_data;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign csr    = ir[31:20];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // x0 is hard-wired to zero; it has no storage entry.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  // --------------------------------------------------------------------------
  // Decode. Anything not matching a supported encoding (including CSR numbers
  // outside the six mapped ports) falls through to OP_ILL and acts as a nop.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    op = OP_ILL;
    case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) op = OP_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0000001) op = OP_MUL;
      end
      7'b0010011: if (funct3 == 3'b000) op = OP_ADDI;
      7'b0000011: if (funct3 == 3'b010) op = OP_LW;
      7'b0100011: if (funct3 == 3'b010) op = OP_SW;
      7'b1101111: op = OP_JAL;
      // jr is jalr x0, rs1, 0; other jalr forms are not part of TinyRV1.
      7'b1100111: if (funct3 == 3'b000 && rd == 5'd0 && csr == 12'd0) op = OP_JR;
      7'b1100011: if (funct3 == 3'b001) op = OP_BNE;
      7'b1110011: begin
        // csrr is csrrs rd, csr, x0; csrw is csrrw x0, csr, rs1.
        if (funct3 == 3'b010 && rs1 == 5'd0 &&
            (csr == 12'hFC2 || csr == 12'hFC3 || csr == 12'hFC4))
          op = OP_CSRR;
        else if (funct3 == 3'b001 && rd == 5'd0 &&
                 (csr == 12'h7C2 || csr == 12'h7C3 || csr == 12'h7C4))
          op = OP_CSRW;
      end
      default: op = OP_ILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Execute: write-back value, next PC and data-memory request.
  // --------------------------------------------------------------------------
  always_comb begin
    wb_en   = 1'b0;
    wb_data = 32'd0;
    next_pc = pc + 32'd4;
    dmem_en = 1'b0;
    case (op)
      OP_ADD:  begin wb_en = 1'b1; wb_data = rs1_val + rs2_val; end
      OP_ADDI: begin wb_en = 1'b1; wb_data = rs1_val + imm_i;   end
      OP_MUL:  begin wb_en = 1'b1; wb_data = rs1_val * rs2_val; end
      OP_LW:   begin wb_en = 1'b1; wb_data = dmemresp_rdata; dmem_en = 1'b1; end
      OP_SW:   dmem_en = 1'b1;
      OP_JAL:  begin wb_en = 1'b1; wb_data = pc + 32'd4; next_pc = pc + imm_j; end
      OP_JR:   next_pc = rs1_val;
      OP_BNE:  if (rs1_val != rs2_val) next_pc = pc + imm_b;
      OP_CSRR: begin
        wb_en = 1'b1;
        case (csr)
          12'hFC2: wb_data = in0;
          12'hFC3: wb_data = in1;
          default: wb_data = in2;
        endcase
      end
      default: ;
    endcase
  end

  // Request/commit strobes are forced low for as long as reset is held.
  assign imemreq_val   = ~rst;
  assign imemreq_addr  = pc;
  assign dmemreq_val   = dmem_en & ~rst;
  assign dmemreq_type  = (op == OP_SW);
  assign dmemreq_addr  = rs1_val + ((op == OP_SW) ? imm_s : imm_i);
  assign dmemreq_wdata = rs2_val;

  assign trace_val  = ~rst;
  assign trace_addr = pc;
  assign trace_data = wb_en ? wb_data : 'x;

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    if (rst) begin
      pc   <= RESET_PC;
      out0 <= 32'd0;
      out1 <= 32'd0;
      out2 <= 32'd0;
    end else begin
      pc <= next_pc;
      if (op == OP_CSRW) begin
        case (csr)
          12'h7C2: out0 <= rs1_val;
          12'h7C3: out1 <= rs1_val;
          default: out2 <= rs1_val;
        endcase
      end
    end
  end

  // NOTE: the register file has no reset so it maps onto plain RAM/flop
  // arrays without a reset network; software must write before reading.
  always_ff @(posedge clk) begin
    if (!rst && wb_en && rd != 5'd0) rf[rd] <= wb_data;
  end

endmodule

// File: tb/tb_proc_scycle.sv
// ---------------------------------------------------------------------------
// tb_proc_scycle -- self-checking bench for proc_scycle.
//
// Programs are held twice: as decoded records (the reference program) and as
// encoded words in the shared instruction/data memory seen by the core. An
// instruction-set-level model steps the decoded records each cycle and its
// results are compared against the commit trace, data requests and CSR
// outputs.
// ---------------------------------------------------------------------------
module tb_proc_scycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic [31:0] in0, in1, in2;
  logic [31:0] out0, out1, out2;
  logic        trace_val;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  int errors = 0;
  int checks = 0;

  proc_scycle dut (
    .clk            (clk),
    .rst            (rst),
    .imemreq_val    (imemreq_val),
    .imemreq_addr   (imemreq_addr),
    .imemresp_data  (imemresp_data),
    .dmemreq_val    (dmemreq_val),
    .dmemreq_type   (dmemreq_type),
    .dmemreq_addr   (dmemreq_addr),
    .dmemreq_wdata  (dmemreq_wdata),
    .dmemresp_rdata (dmemresp_rdata),
    .in0            (in0),
    .in1            (in1),
    .in2            (in2),
    .out0           (out0),
    .out1           (out1),
    .out2           (out2),
    .trace_val      (trace_val),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data)
  );

  always #5 clk = ~clk;

  // Shared memory: words 128..255 hold code (0x200..0x3FC),
  // words 256..511 hold data (0x400..0x7FC).
  logic [31:0] mem [0:511];
  assign imemresp_data  = mem[imemreq_addr[10:2]];
  assign dmemresp_rdata = mem[dmemreq_addr[10:2]];
  always @(posedge clk) begin
    if (dmemreq_val && dmemreq_type) mem[dmemreq_addr[10:2]] = dmemreq_wdata;
  end

  // ---------------- reference model ----------------
  typedef enum {M_ILL, M_ADD, M_ADDI, M_MUL, M_LW, M_SW,
                M_JAL, M_JR, M_BNE, M_CSRR, M_CSRW} mop_e;
  // imm carries the CSR number for csrr/csrw and the raw word for M_ILL.
  typedef struct {
    mop_e op;
    int   rd;
    int   rs1;
    int   rs2;
    int   imm;
  } minst_t;

  minst_t      prog [0:127];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_mem [0:511];
  logic [31:0] m_out [0:2];
  logic [31:0] m_pc;
  int          ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] encode(input minst_t i);
    logic [31:0] im;
    logic [4:0]  d, s1, s2;
    im = i.imm;
    d  = i.rd[4:0];
    s1 = i.rs1[4:0];
    s2 = i.rs2[4:0];
    case (i.op)
      M_ADD:  return {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
      M_MUL:  return {7'b0000001, s2, s1, 3'b000, d, 7'b0110011};
      M_ADDI: return {im[11:0], s1, 3'b000, d, 7'b0010011};
      M_LW:   return {im[11:0], s1, 3'b010, d, 7'b0000011};
      M_SW:   return {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
      M_JAL:  return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
      M_JR:   return {12'd0, s1, 3'b000, 5'd0, 7'b1100111};
      M_BNE:  return {im[12], im[10:5], s2, s1, 3'b001, im[4:1], im[11], 7'b1100011};
      M_CSRR: return {im[11:0], 5'd0, 3'b010, d, 7'b1110011};
      M_CSRW: return {im[11:0], s1, 3'b001, 5'd0, 7'b1110011};
      default: return im;
    endcase
  endfunction

  task automatic emit(input mop_e op, input int rd, input int rs1, input int rs2, input int imm);
    prog[ptr] = '{op, rd, rs1, rs2, imm};
    mem[128 + ptr] = encode(prog[ptr]);
    ptr++;
  endtask

  function automatic logic [31:0] rreg(input int r);
    return (r == 0) ? 32'd0 : m_reg[r];
  endfunction

  // Compare one commit against the model, then advance the model.
  task automatic cycle_check();
    minst_t      i;
    logic [31:0] v, a, npc, exp_data;
    bit          wr, dv;
    int          idx;
    idx = int'((m_pc - 32'h200) >> 2);
    if (idx >= 0 && idx < 128) i = prog[idx];
    else i = '{M_ILL, 0, 0, 0, 0};
    wr = 0; dv = 0; v = 'x; a = '0; npc = m_pc + 32'd4;
    case (i.op)
      M_ADD:  begin wr = 1; v = rreg(i.rs1) + rreg(i.rs2); end
      M_ADDI: begin wr = 1; v = rreg(i.rs1) + i.imm; end
      M_MUL:  begin wr = 1; v = rreg(i.rs1) * rreg(i.rs2); end
      M_LW:   begin wr = 1; dv = 1; a = rreg(i.rs1) + i.imm; v = m_mem[a[10:2]]; end
      M_SW:   begin dv = 1; a = rreg(i.rs1) + i.imm; end
      M_JAL:  begin wr = 1; v = m_pc + 32'd4; npc = m_pc + i.imm; end
      M_JR:   npc = rreg(i.rs1);
      M_BNE:  if (rreg(i.rs1) != rreg(i.rs2)) npc = m_pc + i.imm;
      M_CSRR: begin
        wr = 1;
        v = (i.imm == 'hFC2) ? in0 : (i.imm == 'hFC3) ? in1 : in2;
      end
      default: ;
    endcase
    exp_data = wr ? v : 32'hxxxx_xxxx;
    check("trace_val",    {31'd0, trace_val},   32'd1);
    check("imemreq_val",  {31'd0, imemreq_val}, 32'd1);
    check("imemreq_addr", imemreq_addr, m_pc);
    check("trace_addr",   trace_addr,   m_pc);
    check("trace_data",   trace_data,   exp_data);
    check("dmemreq_val",  {31'd0, dmemreq_val}, {31'd0, dv});
    if (dv) begin
      check("dmemreq_type", {31'd0, dmemreq_type}, {31'd0, i.op == M_SW});
      check("dmemreq_addr", dmemreq_addr, a);
      if (i.op == M_SW) check("dmemreq_wdata", dmemreq_wdata, rreg(i.rs2));
    end
    check("out0", out0, m_out[0]);
    check("out1", out1, m_out[1]);
    check("out2", out2, m_out[2]);
    // commit
    if (wr && i.rd != 0) m_reg[i.rd] = v;
    if (i.op == M_SW) m_mem[a[10:2]] = rreg(i.rs2);
    if (i.op == M_CSRW) m_out[i.imm - 'h7C2] = rreg(i.rs1);
    m_pc = npc;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      cycle_check();
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_trace_val"},   {31'd0, trace_val},   32'd0);
    check({tag, "_imemreq_val"}, {31'd0, imemreq_val}, 32'd0);
    check({tag, "_dmemreq_val"}, {31'd0, dmemreq_val}, 32'd0);
    check({tag, "_out0"}, out0, 32'd0);
    check({tag, "_out1"}, out1, 32'd0);
    check({tag, "_out2"}, out2, 32'd0);
  endtask

  task automatic model_reset();
    m_pc = 32'h200;
    for (int k = 0; k < 3; k++) m_out[k] = '0;
  endtask

  task automatic clear_prog();
    ptr = 0;
    for (int k = 0; k < 128; k++) begin
      prog[k] = '{M_ILL, 0, 0, 0, 0};
      mem[128 + k] = '0;
    end
  endtask

  int          imm, rsel, sel;
  logic [31:0] raw;

  initial begin
    rst = 1'b1;
    in0 = 32'h0000_1234;
    in1 = 32'h7FFF_FFFF;
    in2 = 32'hCAFE_F00D;
    for (int k = 0; k < 32; k++) m_reg[k] = '0;
    for (int k = 0; k < 512; k++) begin
      mem[k]   = $urandom;
      m_mem[k] = mem[k];
    end
    model_reset();

    // ---------------- directed program ----------------
    clear_prog();
    emit(M_ADDI, 1, 0, 0, 2);          // 0x200 -> 2
    emit(M_ADDI, 2, 1, 0, 3);          // -> 5
    emit(M_ADDI, 3, 2, 0, -7);         // -> 0xFFFFFFFE
    emit(M_ADDI, 4, 0, 0, 2047);       // -> 0x7FF
    emit(M_ADDI, 5, 0, 0, -2048);      // -> 0xFFFFF800
    emit(M_ADDI, 0, 0, 0, 5);          // x0 write discarded, trace 5
    emit(M_ADDI, 6, 0, 0, 0);          // -> 0
    emit(M_ADD,  6, 0, 4, 0);          // -> 0x7FF, x0 still 0
    emit(M_CSRR, 8, 0, 0, 'hFC3);      // -> 0x7FFFFFFF
    emit(M_ADDI, 8, 8, 0, 1);          // wrap -> 0x80000000
    emit(M_BNE,  0, 1, 2, 8);          // taken, skips next
    emit(M_ADDI, 1, 0, 0, 99);
    emit(M_SW,   0, 0, 3, 'h400);
    emit(M_LW,   9, 0, 0, 'h400);      // -> stored 0xFFFFFFFE
    emit(M_CSRR, 10, 0, 0, 'hFC2);     // -> 0x1234
    emit(M_CSRW, 0, 10, 0, 'h7C2);
    emit(M_CSRW, 0, 2, 0, 'h7C3);
    emit(M_CSRW, 0, 3, 0, 'h7C4);
    emit(M_MUL,  11, 3, 2, 0);         // -2 * 5
    emit(M_ADD,  12, 8, 8, 0);         // carry dropped -> 0
    emit(M_BNE,  0, 1, 1, 8);          // not taken
    emit(M_JAL,  13, 0, 0, 8);         // skips next
    emit(M_ADDI, 1, 0, 0, 77);
    emit(M_ADDI, 14, 0, 0, 'h390);
    emit(M_JR,   0, 14, 0, 0);
    emit(M_ADDI, 1, 0, 0, 55);
    ptr = 100;                         // 0x390
    emit(M_ILL,  0, 0, 0, 32'hFFFF_FFFF);
    emit(M_LW,   15, 0, 0, 'h7FC);
    emit(M_JAL,  0, 0, 0, 0);          // park

    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    run(40);

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    check("midreset_pc", imemreq_addr, 32'h200);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(12);

    // ---------------- randomized programs ----------------
    for (int p = 0; p < 3; p++) begin
      rst = 1'b1;
      in0 = $urandom;
      in1 = $urandom;
      in2 = $urandom;
      model_reset();
      clear_prog();
      for (int r = 1; r < 8; r++) begin
        imm = int'($urandom_range(0, 4095)) - 2048;
        emit(M_ADDI, r, 0, 0, imm);
      end
      for (int j = 0; j < 80; j++) begin
        sel  = int'($urandom_range(0, 9));
        rsel = int'($urandom_range(0, 7));
        imm  = 1024 + 4 * int'($urandom_range(0, 255));
        case (sel)
          0: emit(M_ADD,  rsel, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0);
          1: emit(M_ADDI, rsel, int'($urandom_range(0, 7)), 0, int'($urandom_range(0, 4095)) - 2048);
          2: emit(M_MUL,  rsel, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0);
          3: emit(M_LW,   rsel, 0, 0, imm);
          4: emit(M_SW,   0, 0, int'($urandom_range(0, 7)), imm);
          5: emit(M_CSRR, rsel, 0, 0, 'hFC2 + int'($urandom_range(0, 2)));
          6: emit(M_CSRW, 0, int'($urandom_range(0, 7)), 0, 'h7C2 + int'($urandom_range(0, 2)));
          7: emit(M_BNE,  0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 8);
          8: begin
            raw = $urandom;
            raw[6:0] = 7'h7F;
            emit(M_ILL, 0, 0, 0, int'(raw));
          end
          default: emit(M_JAL, rsel, 0, 0, 8);
        endcase
      end
      emit(M_JAL, 0, 0, 0, 0);
      emit(M_JAL, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      run(100);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
